c7bbiu_ird: RTL and testbench
=============================

Name: c7bbiu_ird

Overview:
- BIU read responder serving the ICU's linefill/single-read requests.
- Accepts icu_biu_req with a one-cycle ack and issues one AXI4 read burst: 4 beats for a line fill, 1 beat for a single read.
- Returns beats to the ICU as registered biu_icu_data_valid pulses, with biu_icu_data_last on the final beat and a fault flag.
- Sits between the ICU and the system AXI read channels; the write channels are out of scope.

Parameters:
AXI_ID, 4'h0, ARID driven on every request; RID expected on every beat.

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
icu_biu_req  in  1  ICU read request, held until ack
icu_biu_addr  in  29  [31:3] request address
icu_biu_single  in  1  1 = single 64-bit read, 0 = 32-byte line fill
biu_icu_ack  out  1  request accepted (one-cycle pulse)
biu_icu_data_valid  out  1  return beat valid
biu_icu_data_last  out  1  final beat of the transfer
biu_icu_data  out  64  return data
biu_icu_fault  out  1  error on this beat; sticky to last beat
arid  out  4  AXI read id (= AXI_ID)
araddr  out  32  AXI read address
arlen  out  8  burst length - 1
arsize  out  3  fixed 3'b011 (8 bytes)
arburst  out  2  fixed 2'b01 (INCR)
arvalid  out  1  address valid
arready  in  1  address ready
rid  in  4  read id
rdata  in  64  read data
rresp  in  2  read response
rlast  in  1  AXI last beat
rvalid  in  1  read valid
rready  out  1  read ready

Behaviour:
- Reset: state IDLE. biu_icu_ack, biu_icu_data_valid, biu_icu_data_last, biu_icu_fault, arvalid and rready are 0. biu_icu_data, araddr and arlen are 0. Reset takes effect immediately, including mid-burst.
- FSM states: IDLE, AR, RD.
- IDLE:
  - biu_icu_ack = icu_biu_req & (state==IDLE), combinational, so the ack lands in the request cycle.
  - On ack, go to AR and capture:
    - araddr = {addr[31:5],5'b0} with arlen=3 when single=0.
    - araddr = {addr[31:3],3'b0} with arlen=0 when single=1.
  - Clear the beat counter and the sticky fault.
- AR:
  - arvalid=1; araddr and arlen stay stable until the arready handshake.
  - On arvalid&arready, go to RD.
  - arready stalls of any length are legal.
- RD:
  - rready=1 throughout; the ICU cannot backpressure.
  - Each accepted beat (rvalid&rready) registers data to the ICU side one cycle later: biu_icu_data_valid=1, biu_icu_data=rdata.
  - The 2-bit beat counter increments per accepted beat.
  - Beat error = rresp[1] | (rid!=AXI_ID). It sets biu_icu_fault on that beat and sets the sticky fault.
  - Final beat is counter==arlen[1:0], decided by the counter and not by rlast.
    - On the final beat, register biu_icu_data_last=1 and biu_icu_fault = beat error | sticky fault | (rlast==0).
    - Next state is IDLE.
  - rlast=1 on a non-final beat is a protocol error: set the sticky fault and keep counting.
  - rvalid gaps are legal; outputs stay 0 during gaps.
- Output pulse rules:
  - biu_icu_data_valid, biu_icu_data_last and biu_icu_fault are single-cycle pulses; biu_icu_data holds its last value.
  - Latency: AXI beat accepted at cycle N appears on the ICU side at N+1.
  - Minimum line fill: ack T0, arvalid T1; with arready at T1, beats T2..T5 appear at T3..T6.
- Back-to-back requests:
  - The FSM is IDLE in the cycle biu_icu_data_last is high, so a request present then may be acked.
  - The ICU masks its request while busy, so the next ack normally comes no earlier than last+1.
- Only one transaction is outstanding at a time. icu_biu_req while not IDLE is ignored (no ack) until IDLE.
- The ICU's cancel never reaches this block; every acked burst always runs to completion.

Test Plan:
- Line fill:
  - Stimulus: req with addr[31:3]=29'h0000_1234, single=0; arready=1; 4 back-to-back beats with rdata=64'hA0..A3, rlast on beat 4.
  - Response: ack at T0, araddr=32'h0000_91A0, arlen=3.
  - data_valid at 4 consecutive cycles with data A0..A3; last only with A3; fault=0.
- arready held low 5 cycles and 2-cycle rvalid gaps between beats -> araddr/arlen stable throughout the stall; exactly 4 data_valid pulses; no valid during gaps.
- Errors:
  - rresp=2'b10 on beat 2 -> fault=1 on beat 2 and again on the last beat; beats 3/4 still delivered.
  - Separate burst with rid=4'h5 (mismatch) -> same fault pattern.
- Single read:
  - Stimulus: single=1, addr[31:3]=29'h1 -> araddr=32'h8, arlen=0.
  - Response: one beat with valid and last together.
  - rlast=0 on that beat -> fault=1.
- Back-to-back:
  - req held while in RD -> no ack until IDLE.
  - req asserted in the last cycle -> ack that cycle; the next AR follows the next cycle.
- Reset:
  - resetn low after beat 2 of a burst -> all outputs 0 at once, state IDLE.
  - A new req after release -> acked and completes normally.

Source files
------------

// File: rtl/c7bbiu_ird.sv
// c7bbiu_ird: BIU read responder for ICU linefill and single reads.
// One AXI4 INCR read burst per acked request, beats returned a cycle later.
module c7bbiu_ird #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        icu_biu_req,
  input  logic [28:0] icu_biu_addr,
  input  logic        icu_biu_single,
  output logic        biu_icu_ack,
  output logic        biu_icu_data_valid,
  output logic        biu_icu_data_last,
  output logic [63:0] biu_icu_data,
  output logic        biu_icu_fault,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    RD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0] cnt;
  logic       sticky;
  logic       beat;
  logic       err;
  logic       fin;

  assign biu_icu_ack = icu_biu_req & (state == IDLE);
  assign arvalid     = (state == AR);
  assign rready      = (state == RD);
  assign arid        = AXI_ID;
  assign arsize      = 3'b011;
  assign arburst     = 2'b01;

  assign beat = rvalid & rready;
  assign err  = rresp[1] | (rid != AXI_ID);
  // End of burst is set by our own count; rlast only feeds fault checks
  assign fin  = (cnt == arlen[1:0]);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (biu_icu_ack) state_nxt = AR;
      AR:   if (arready) state_nxt = RD;
      RD:   if (beat && fin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr <= '0;
      arlen  <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (biu_icu_ack) begin
      cnt    <= '0;
      sticky <= 1'b0;
      if (icu_biu_single) begin
        araddr <= {icu_biu_addr, 3'b000};
        arlen  <= 8'd0;
      end else begin
        araddr <= {icu_biu_addr[28:2], 5'b00000};
        arlen  <= 8'd3;
      end
    end else if (beat) begin
      cnt    <= cnt + 2'd1;
      sticky <= sticky | err | (rlast & ~fin);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      biu_icu_data_valid <= 1'b0;
      biu_icu_data_last  <= 1'b0;
      biu_icu_fault      <= 1'b0;
      biu_icu_data       <= '0;
    end else begin
      biu_icu_data_valid <= beat;
      biu_icu_data_last  <= beat & fin;
      biu_icu_fault      <= 1'b0;
      if (beat) begin
        biu_icu_data  <= rdata;
        biu_icu_fault <= fin ? (err | sticky | ~rlast) : err;
      end
    end
  end

endmodule

// File: tb/tb_c7bbiu_ird.sv
// tb_c7bbiu_ird: directed AXI read stimulus with a queued beat scoreboard.
// The monitor pops one expected beat per ICU data_valid pulse.
module tb_c7bbiu_ird;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic [28:0] addr = '0;
  logic        single = 1'b0;
  logic        ack;
  logic        dv;
  logic        last;
  logic [63:0] data;
  logic        fault;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        f;
    int          c;
  } exp_t;

  exp_t q[$];

  c7bbiu_ird dut (
    .clk(clk),
    .resetn(resetn),
    .icu_biu_req(req),
    .icu_biu_addr(addr),
    .icu_biu_single(single),
    .biu_icu_ack(ack),
    .biu_icu_data_valid(dv),
    .biu_icu_data_last(last),
    .biu_icu_data(data),
    .biu_icu_fault(fault),
    .arid(arid),
    .araddr(araddr),
    .arlen(arlen),
    .arsize(arsize),
    .arburst(arburst),
    .arvalid(arvalid),
    .arready(arready),
    .rid(rid),
    .rdata(rdata),
    .rresp(rresp),
    .rlast(rlast),
    .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn) begin
      if (dv === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid data=%h cyc=%0d", data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (data !== e.d || last !== e.l || fault !== e.f || cyc != e.c) begin
            errors++;
            $display("FAIL beat got d=%h l=%b f=%b c=%0d exp d=%h l=%b f=%b c=%0d",
                     data, last, fault, cyc, e.d, e.l, e.f, e.c);
          end
        end
      end else if (last !== 1'b0 || fault !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL orphan_pulse last=%b fault=%b exp 0 0", last, fault);
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs();
    chk("rst_ack", 64'(ack), 0);
    chk("rst_dv", 64'(dv), 0);
    chk("rst_last", 64'(last), 0);
    chk("rst_fault", 64'(fault), 0);
    chk("rst_arvalid", 64'(arvalid), 0);
    chk("rst_rready", 64'(rready), 0);
    chk("rst_data", data, 0);
    chk("rst_araddr", 64'(araddr), 0);
    chk("rst_arlen", 64'(arlen), 0);
  endtask

  task automatic do_req(input logic [28:0] a, input logic s,
                        input logic [31:0] ea, input logic [7:0] el);
    req = 1'b1;
    addr = a;
    single = s;
    #1;
    chk("ack", 64'(ack), 1);
    step();
    req = 1'b0;
    chk("arvalid", 64'(arvalid), 1);
    chk("araddr", 64'(araddr), 64'(ea));
    chk("arlen", 64'(arlen), 64'(el));
    chk("arfix", 64'({arid, arsize, arburst}), 64'({4'h0, 3'b011, 2'b01}));
  endtask

  task automatic ar_hs(input int stall, input logic [31:0] ea, input logic [7:0] el);
    arready = 1'b0;
    repeat (stall) begin
      step();
      chk("stall_arvalid", 64'(arvalid), 1);
      chk("stall_araddr", 64'(araddr), 64'(ea));
      chk("stall_arlen", 64'(arlen), 64'(el));
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rd_rready", 64'(rready), 1);
    chk("rd_arvalid", 64'(arvalid), 0);
  endtask

  task automatic beat(input int gap, input logic [63:0] d, input logic [1:0] rs,
                      input logic [3:0] id, input logic rl,
                      input logic el, input logic ef);
    rvalid = 1'b0;
    repeat (gap) step();
    if (req) chk("ack_busy", 64'(ack), 0);
    rvalid = 1'b1;
    rdata = d;
    rresp = rs;
    rid = id;
    rlast = rl;
    q.push_back('{d: d, l: el, f: ef, c: cyc + 1});
    step();
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    rid = 4'h0;
  endtask

  initial begin
    #2;
    chk_idle_outs();
    step();
    resetn = 1'b1;
    step();

    // minimum-latency line fill
    do_req(29'h0000_1234, 1'b0, 32'h0000_91A0, 8'd3);
    ar_hs(0, 32'h0000_91A0, 8'd3);
    beat(0, 64'hA0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hA1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hA2, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hA3, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0);
    step();

    // arready stall and rvalid gaps
    do_req(29'h0000_0407, 1'b0, 32'h0000_2020, 8'd3);
    ar_hs(5, 32'h0000_2020, 8'd3);
    beat(0, 64'hB0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(2, 64'hB1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(2, 64'hB2, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(2, 64'hB3, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0);
    step();

    // SLVERR on beat 2
    do_req(29'h0000_0100, 1'b0, 32'h0000_0800, 8'd3);
    ar_hs(1, 32'h0000_0800, 8'd3);
    beat(0, 64'hC0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hC1, 2'b10, 4'h0, 1'b0, 1'b0, 1'b1);
    beat(0, 64'hC2, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hC3, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1);
    step();

    // rid mismatch on beat 2
    do_req(29'h0000_0200, 1'b0, 32'h0000_1000, 8'd3);
    ar_hs(0, 32'h0000_1000, 8'd3);
    beat(0, 64'hD0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hD1, 2'b00, 4'h5, 1'b0, 1'b0, 1'b1);
    beat(0, 64'hD2, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hD3, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1);
    step();

    // early rlast on beat 2 faults only the last beat
    do_req(29'h0000_0300, 1'b0, 32'h0000_1800, 8'd3);
    ar_hs(0, 32'h0000_1800, 8'd3);
    beat(0, 64'hE0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hE1, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0);
    beat(0, 64'hE2, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hE3, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1);
    step();

    // single read with missing rlast
    do_req(29'h0000_0001, 1'b1, 32'h0000_0008, 8'd0);
    ar_hs(0, 32'h0000_0008, 8'd0);
    beat(0, 64'h1111_2222_3333_4444, 2'b00, 4'h0, 1'b0, 1'b1, 1'b1);
    step();

    // request held during RD, acked in the last-beat cycle
    do_req(29'h0000_0040, 1'b0, 32'h0000_0200, 8'd3);
    ar_hs(0, 32'h0000_0200, 8'd3);
    req = 1'b1;
    addr = 29'h0000_0002;
    single = 1'b1;
    beat(0, 64'hF0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(1, 64'hF1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hF2, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'hF3, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("last_now", 64'(last), 1);
    do_req(29'h0000_0002, 1'b1, 32'h0000_0010, 8'd0);
    ar_hs(0, 32'h0000_0010, 8'd0);
    beat(0, 64'h5A5A, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0);
    step();

    // reset mid-burst after beat 2
    do_req(29'h0000_0500, 1'b0, 32'h0000_2800, 8'd3);
    ar_hs(0, 32'h0000_2800, 8'd3);
    beat(0, 64'h70, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'h71, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_idle_outs();
    req = 1'b1;
    #1;
    chk("rst_state_idle", 64'(ack), 1);
    req = 1'b0;
    step();
    resetn = 1'b1;
    step();
    do_req(29'h0000_0010, 1'b0, 32'h0000_0080, 8'd3);
    ar_hs(0, 32'h0000_0080, 8'd3);
    beat(0, 64'h80, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'h81, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'h82, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    beat(0, 64'h83, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0);

    repeat (4) step();
    chk("queue_drained", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
